// File: rtl/servo_cmd_rx_if.sv
// Byte-stream handshake between a byte source and servo_cmd_rx.
// Ports: in_data (byte), in_valid (source has a byte), in_ready (sink takes it).
interface servo_cmd_rx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/servo_cmd_rx.sv
// Servo command decoder: parses FF/CH/VAL/CS packets into a position bank.
// Ports: clk, res (async, active-high), bus (slave byte handshake),
//   servo_data (flat positions, channel i at [i*8 +: 8]),
//   pkt_ok / pkt_err (one-cycle pulses), err_cnt (saturating reject count).
// Optional SERVO_CMD_SHADOW_EN: writes land in a shadow bank; commit copies all.
module servo_cmd_rx #(
    parameter int          SERVO_CNT  = 18,
    parameter int          RESOLUTION = 8,
    parameter logic [7:0]  RESET_POS  = 8'd128
) (
    input  logic                              clk,
    input  logic                              res,
    servo_cmd_rx_if.slave                     bus,
    output logic [SERVO_CNT*RESOLUTION-1:0]   servo_data,
    output logic                              pkt_ok,
    output logic                              pkt_err,
    output logic [7:0]                        err_cnt
);

    localparam logic [7:0] SYNC   = 8'hFF;
    localparam logic [7:0] COMMIT = 8'h80;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHAN  = 3'd1;
    localparam logic [2:0] ST_VALUE = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_APPLY = 3'd4;

    if (RESOLUTION != 8 || SERVO_CNT < 1 || SERVO_CNT > 127) begin : g_bad_cfg
        $error("servo_cmd_rx: unsupported SERVO_CNT/RESOLUTION");
    end

    logic [2:0] state;
    logic [7:0] ch_r;
    logic [7:0] val_r;
    logic [7:0] cs_r;
    logic [7:0] pos [SERVO_CNT];

    logic xfer;
    logic is_sync;
    logic abort;
    logic is_commit;
    logic ch_valid;
    logic csum_ok;
    logic apply_ok;
    logic apply_err;

    // Ready is forced low while reset is held, not just by the FSM state.
    assign bus.in_ready = !res && (state != ST_APPLY);

    assign xfer      = bus.in_valid && bus.in_ready;
    assign is_sync   = (bus.in_data == SYNC);
    // A sync byte inside a packet restarts framing; APPLY never transfers.
    assign abort     = xfer && is_sync && (state != ST_IDLE);

    assign is_commit = (ch_r == COMMIT);
    assign ch_valid  = (ch_r < 8'(SERVO_CNT));
    assign csum_ok   = ((ch_r ^ val_r) == cs_r);
    assign apply_ok  = (state == ST_APPLY) && csum_ok && (is_commit || ch_valid);
    assign apply_err = (state == ST_APPLY) && !(csum_ok && (is_commit || ch_valid));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
            ch_r  <= 8'h00;
            val_r <= 8'h00;
            cs_r  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer && is_sync) state <= ST_CHAN;
                end
                ST_CHAN: begin
                    if (xfer) begin
                        if (is_sync) begin
                            state <= ST_CHAN;
                        end else begin
                            ch_r  <= bus.in_data;
                            state <= ST_VALUE;
                        end
                    end
                end
                ST_VALUE: begin
                    if (xfer) begin
                        if (is_sync) begin
                            state <= ST_CHAN;
                        end else begin
                            val_r <= bus.in_data;
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (is_sync) begin
                            state <= ST_CHAN;
                        end else begin
                            cs_r  <= bus.in_data;
                            state <= ST_APPLY;
                        end
                    end
                end
                ST_APPLY: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            pkt_ok  <= apply_ok;
            pkt_err <= apply_err || abort;
            if ((apply_err || abort) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end

`ifdef SERVO_CMD_SHADOW_EN
    logic [7:0] shadow [SERVO_CNT];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < SERVO_CNT; i++) begin
                pos[i]    <= RESET_POS;
                shadow[i] <= RESET_POS;
            end
        end else if (apply_ok) begin
            if (is_commit) begin
                for (int i = 0; i < SERVO_CNT; i++) begin
                    pos[i] <= shadow[i];
                end
            end else begin
                for (int i = 0; i < SERVO_CNT; i++) begin
                    if (ch_r == 8'(i)) shadow[i] <= val_r;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < SERVO_CNT; i++) begin
                pos[i] <= RESET_POS;
            end
        end else if (apply_ok && !is_commit) begin
            for (int i = 0; i < SERVO_CNT; i++) begin
                if (ch_r == 8'(i)) pos[i] <= val_r;
            end
        end
    end
`endif

    for (genvar g = 0; g < SERVO_CNT; g++) begin : g_out
        assign servo_data[g*RESOLUTION +: RESOLUTION] = pos[g];
    end

endmodule

// File: tb/tb_servo_cmd_rx.sv
// Testbench for servo_cmd_rx: directed and random packet streams
// checked against a packet-level reference model.
module tb_servo_cmd_rx;

    localparam int N = 18;

    typedef logic [7:0] bq_t[$];

    logic           clk;
    logic           res;
    logic [N*8-1:0] servo_data;
    logic           pkt_ok;
    logic           pkt_err;
    logic [7:0]     err_cnt;

    servo_cmd_rx_if bus ();

    servo_cmd_rx #(
        .SERVO_CNT  (N),
        .RESOLUTION (8),
        .RESET_POS  (8'd128)
    ) dut (
        .clk        (clk),
        .res        (res),
        .bus        (bus),
        .servo_data (servo_data),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet-level view of the stream
    logic [7:0] m_pos [N];
    logic [7:0] m_sh  [N];
    int         m_err;
    bit         m_in;
    logic [7:0] m_q [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pos[i] = 8'h80;
            m_sh[i]  = 8'h80;
        end
        m_err = 0;
        m_in  = 0;
        m_q.delete();
    endfunction

    function automatic logic [N*8-1:0] exp_bus();
        logic [N*8-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) b[i*8 +: 8] = m_pos[i];
        return b;
    endfunction

    task automatic model_byte(input logic [7:0] b, output bit abort,
                              output bit done, output logic [7:0] c,
                              output logic [7:0] v, output logic [7:0] s);
        abort = 0;
        done  = 0;
        c = 0; v = 0; s = 0;
        if (b == 8'hFF) begin
            if (m_in) begin
                abort = 1;
                if (m_err < 255) m_err++;
            end
            m_in = 1;
            m_q.delete();
        end else if (m_in) begin
            m_q.push_back(b);
            if (m_q.size() == 3) begin
                done = 1;
                c = m_q[0]; v = m_q[1]; s = m_q[2];
                m_in = 0;
                m_q.delete();
            end
        end
    endtask

    function automatic bit model_apply(input logic [7:0] c, input logic [7:0] v,
                                       input logic [7:0] s);
        bit ok;
        ok = ((c ^ v) == s) && (int'(c) < N || c == 8'h80);
        if (!ok) begin
            if (m_err < 255) m_err++;
        end else if (c == 8'h80) begin
`ifdef SERVO_CMD_SHADOW_EN
            for (int i = 0; i < N; i++) m_pos[i] = m_sh[i];
`endif
        end else begin
`ifdef SERVO_CMD_SHADOW_EN
            m_sh[int'(c)] = v;
`else
            m_pos[int'(c)] = v;
`endif
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag);
        logic [N*8-1:0] e;
        e = exp_bus();
        checks++;
        assert (servo_data === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, servo_data, e);
        end
    endtask

    task automatic chk_outputs(input string tag, input bit e_ok, input bit e_er);
        chk({tag, ".pkt_ok"}, 32'(pkt_ok), 32'(e_ok));
        chk({tag, ".pkt_err"}, 32'(pkt_err), 32'(e_er));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
        chk_bus({tag, ".servo_data"});
    endtask

    // Keeps in_valid high for the whole stream; counts cycles with ready low.
    task automatic send_stream(input string tag, input bq_t bytes);
        bit         pend;
        logic [7:0] pc, pv, ps;
        logic [7:0] c, v, s;
        bit         abort, done, e_ok, e_er, r;
        int         lows, pkts, guard;
        pend = 0; lows = 0; pkts = 0;
        pc = 0; pv = 0; ps = 0;
        foreach (bytes[k]) begin
            bus.in_data  = bytes[k];
            bus.in_valid = 1'b1;
            guard = 0;
            forever begin
                @(negedge clk);
                r = bus.in_ready;
                chk({tag, ".in_ready"}, 32'(r), 32'(!pend));
                if (!r) lows++;
                @(posedge clk);
                #1;
                e_ok = 0;
                e_er = 0;
                if (pend) begin
                    pend = 0;
                    if (model_apply(pc, pv, ps)) e_ok = 1;
                    else e_er = 1;
                end
                if (r) begin
                    model_byte(bytes[k], abort, done, c, v, s);
                    if (abort) e_er = 1;
                    if (done) begin
                        pend = 1;
                        pc = c; pv = v; ps = s;
                        pkts++;
                    end
                end
                chk_outputs(tag, e_ok, e_er);
                if (r) break;
                guard++;
                if (guard > 4) begin
                    chk({tag, ".timeout"}, 32'(guard), 32'd0);
                    break;
                end
            end
        end
        if (pend) begin
            @(negedge clk);
            r = bus.in_ready;
            chk({tag, ".in_ready"}, 32'(r), 32'd0);
            if (!r) lows++;
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (model_apply(pc, pv, ps)) chk_outputs(tag, 1, 0);
            else chk_outputs(tag, 0, 1);
        end
        bus.in_valid = 1'b0;
        chk({tag, ".ready_low_cycles"}, 32'(lows), 32'(pkts));
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        res = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        #1;
        chk({tag, ".ready_in_reset"}, 32'(bus.in_ready), 32'd0);
        chk_outputs({tag, ".in_reset"}, 0, 0);
        @(negedge clk);
        res = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".ready_after"}, 32'(bus.in_ready), 32'd1);
        chk_outputs({tag, ".after"}, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        logic [7:0] ch, val, cs;
        res = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        res = 1'b0;

        do_reset("reset");

        send_stream("single", '{8'hFF, 8'h05, 8'h64, 8'h61});
        send_stream("bad_cs", '{8'hFF, 8'h03, 8'h40, 8'h00});
        chk("bad_cs.err_cnt", 32'(err_cnt), 32'd1);
        send_stream("bad_ch", '{8'hFF, 8'h12, 8'h01, 8'h13});
        chk("bad_ch.err_cnt", 32'(err_cnt), 32'd2);
        send_stream("resync", '{8'hFF, 8'h02, 8'hFF, 8'h02, 8'h30, 8'h32});
        send_stream("idle_noise", '{8'h00, 8'h12, 8'h34, 8'hFE});
        send_stream("shadow_wr", '{8'hFF, 8'h00, 8'h10, 8'h10,
                                   8'hFF, 8'h11, 8'h20, 8'h31});
        send_stream("commit", '{8'hFF, 8'h80, 8'h00, 8'h80});

        q.delete();
        for (int p = 0; p < 40; p++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) ch = 8'($urandom_range(0, N - 1));
            else if (r < 8) ch = 8'h80;
            else ch = 8'($urandom_range(0, 254));
            val = 8'($urandom_range(0, 254));
            cs  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : (ch ^ val);
            if ($urandom_range(0, 7) == 0) q.push_back(8'($urandom_range(0, 254)));
            q.push_back(8'hFF);
            q.push_back(ch);
            q.push_back(val);
            q.push_back(cs);
        end
        q.push_back(8'hFF);
        q.push_back(8'h80);
        q.push_back(8'h07);
        q.push_back(8'h87);
        send_stream("random", q);

        send_stream("partial", '{8'hFF, 8'h07});
        do_reset("mid_pkt_reset");
        send_stream("orphan", '{8'h07, 8'h11, 8'h16});
        send_stream("after_reset", '{8'hFF, 8'h07, 8'h11, 8'h16});

        q.delete();
        for (int p = 0; p < 300; p++) begin
            q.push_back(8'hFF);
            q.push_back(8'h01);
            q.push_back(8'h01);
            q.push_back(8'h01);
        end
        send_stream("saturate", q);
        chk("saturate.err_cnt", 32'(err_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
